// File: rtl/sobel_radicand_gen.sv
// sobel_radicand_gen: bit-serial Gx^2 + Gy^2 radicand engine
// Saturates to OUT_W bits and hands off over valid/ready.
module sobel_radicand_gen #(
    parameter int IN_W  = 11,
    parameter int OUT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] gx,
    input  logic signed [IN_W-1:0] gy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       radicand,
    output logic                   sat
);

    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int ACC_W = 2 * IN_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(IN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SQX,
        S_SQY,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [IN_W-1:0]  r_mag_x;
    logic [IN_W-1:0]  r_mag_y;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [OUT_W-1:0] r_radicand;
    logic             r_sat;

    logic [IN_W-1:0]  w_abs_x;
    logic [IN_W-1:0]  w_abs_y;
    logic [IN_W-1:0]  w_mag;
    logic             w_bit;
    logic             w_last;
    logic             w_accept;
    logic [ACC_W-1:0] w_shift;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_sat;

    // Two's-complement magnitude; -2^(IN_W-1) maps to 2^(IN_W-1) unsigned.
    assign w_abs_x = gx[IN_W-1] ? (~gx + 1'b1) : gx;
    assign w_abs_y = gy[IN_W-1] ? (~gy + 1'b1) : gy;

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign radicand  = r_radicand;
    assign sat       = r_sat;
    assign w_accept  = in_valid && in_ready;

    // One shift-add step of the multiplier currently squaring.
    assign w_mag      = (r_state == S_SQX) ? r_mag_x : r_mag_y;
    assign w_bit      = w_mag[r_cnt];
    assign w_last     = (r_cnt == LAST);
    assign w_shift    = ACC_W'(w_mag) << r_cnt;
    assign w_acc_next = r_acc + (w_bit ? w_shift : '0);
    assign w_sat      = |w_acc_next[ACC_W-1:OUT_W];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_state_next = S_SQX;
            S_SQX:  if (w_last) w_state_next = S_SQY;
            S_SQY:  if (w_last) w_state_next = S_DONE;
            S_DONE: if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: capture, accumulate, and load the saturated result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mag_x    <= '0;
            r_mag_y    <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_radicand <= '0;
            r_sat      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mag_x <= w_abs_x;
                        r_mag_y <= w_abs_y;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_SQX, S_SQY: begin
                    r_acc <= w_acc_next;
                    r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                    if (r_state == S_SQY && w_last) begin
                        r_radicand <= w_sat ? '1 : w_acc_next[OUT_W-1:0];
                        r_sat      <= w_sat;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_radicand_gen.sv
// tb_sobel_radicand_gen: randomized bench for sobel_radicand_gen
// Results are compared against an arithmetic sum-of-squares model.
module tb_sobel_radicand_gen;

    localparam int IN_W  = 11;
    localparam int OUT_W = 16;
    localparam int LAT   = 2 * IN_W;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic signed [IN_W-1:0] gx;
    logic signed [IN_W-1:0] gy;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_W-1:0]       radicand;
    logic                   sat;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    sobel_radicand_gen #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .gx        (gx),
        .gy        (gy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .radicand  (radicand),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: true sum of squares, saturated to the output width.
    function automatic int model_sum(input int x, input int y);
        return x * x + y * y;
    endfunction

    function automatic int model_rad(input int s);
        return (s >= (1 << OUT_W)) ? (1 << OUT_W) - 1 : s;
    endfunction

    task automatic run_txn(input string name,
                           input logic signed [IN_W-1:0] x,
                           input logic signed [IN_W-1:0] y,
                           input int stall,
                           input bit noise,
                           output int acc_cyc);
        int  s;
        int  exp_r;
        bit  exp_s;
        int  lat;
        bit  busy_ok;
        bit  hold_ok;
        s     = model_sum(int'(x), int'(y));
        exp_r = model_rad(s);
        exp_s = (s >= (1 << OUT_W));
        acc_cyc = -1;
        gx = x;
        gy = y;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        for (int i = 0; i < 50 && !in_ready; i++) step();
        if (!in_ready) begin
            failures++;
            checks++;
            $display("FAIL %s accept_timeout in_ready=%0b want 1", name, in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        in_valid = noise;
        busy_ok = 1'b1;
        lat = 0;
        while (!out_valid && lat < 60) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            if (noise) begin
                gx = IN_W'($urandom);
                gy = IN_W'($urandom);
            end
            step();
            lat++;
        end
        checks++;
        if (lat !== LAT) begin
            failures++;
            $display("FAIL %s latency got=%0d want=%0d", name, lat, LAT);
        end
        checks++;
        if (!busy_ok) begin
            failures++;
            $display("FAIL %s busy_in_ready got=1 want=0", name);
        end
        hold_ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                radicand !== OUT_W'(exp_r) || sat !== exp_s)
                hold_ok = 1'b0;
            if (noise) begin
                gx = IN_W'($urandom);
                gy = IN_W'($urandom);
            end
            step();
        end
        if (stall > 0) begin
            checks++;
            if (!hold_ok) begin
                failures++;
                $display("FAIL %s stall_hold ov=%0b rdy=%0b rad=%0d want=%0d",
                         name, out_valid, in_ready, radicand, exp_r);
            end
        end
        out_ready = 1'b1;
        checks++;
        if (radicand !== OUT_W'(exp_r)) begin
            failures++;
            $display("FAIL %s radicand got=%0d want=%0d", name, radicand, exp_r);
        end
        checks++;
        if (sat !== exp_s) begin
            failures++;
            $display("FAIL %s sat got=%0b want=%0b", name, sat, exp_s);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s handoff ov=%0b rdy=%0b want ov=0 rdy=1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        gx = '0;
        gy = '0;
        step();
        step();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs rdy=%0b ov=%0b want 0 0", in_ready, out_valid);
        end
        checks++;
        if (radicand !== '0 || sat !== 1'b0) begin
            failures++;
            $display("FAIL reset_out rad=%0d sat=%0b want 0 0", radicand, sat);
        end
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release in_ready=%0b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        int a;
        run_txn("basic_3_4", 11'sd3, 11'sd4, 0, 1'b0, a);
        run_txn("neg255_0", -11'sd255, 11'sd0, 0, 1'b0, a);
        run_txn("b181_181", 11'sd181, 11'sd181, 0, 1'b0, a);
        run_txn("b256_0", 11'sd256, 11'sd0, 0, 1'b0, a);
        run_txn("min_max", -11'sd1024, 11'sd1023, 0, 1'b0, a);
        run_txn("zero_zero", 11'sd0, 11'sd0, 0, 1'b0, a);
    endtask

    task automatic test_random();
        int a;
        logic signed [IN_W-1:0] x;
        logic signed [IN_W-1:0] y;
        for (int i = 0; i < 24; i++) begin
            x = IN_W'($urandom);
            y = (i < 12) ? IN_W'($urandom_range(0, 400)) - 11'sd200
                         : IN_W'($urandom);
            run_txn("random", x, y, 0, 1'b0, a);
        end
    endtask

    task automatic test_backpressure();
        int a;
        run_txn("bp_noise", -11'sd150, 11'sd200, 5, 1'b1, a);
        run_txn("bp_next", 11'sd7, -11'sd9, 0, 1'b0, a);
    endtask

    task automatic test_back_to_back();
        int a1;
        int a2;
        run_txn("b2b_first", 11'sd12, 11'sd34, 0, 1'b0, a1);
        run_txn("b2b_second", -11'sd56, 11'sd78, 0, 1'b0, a2);
        checks++;
        if (a2 - a1 !== LAT + 2) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d want=%0d", a2 - a1, LAT + 2);
        end
    endtask

    task automatic test_reset_mid();
        int  a;
        bit  seen;
        gx = 11'sd100;
        gy = 11'sd100;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 14; i++) step();
        rst = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_during in_ready=%0b want 0", in_ready);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_after rdy=%0b ov=%0b want 1 0",
                     in_ready, out_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL midrst_no_output out_valid seen=1 want 0");
        end
        run_txn("post_rst_1_m1", 11'sd1, -11'sd1, 0, 1'b0, a);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sobel_radicand_gen.md
# sobel_radicand_gen

Sequential sum-of-squares engine producing the 16-bit radicand Gx² + Gy² for the approximate square-root stage of the Sobel edge path. It accepts one signed gradient pair per transaction over a valid/ready handshake and squares each magnitude with a bit-serial shift-add multiplier. It saturates the sum to the output width and presents it over a second valid/ready handshake to the square-root unit.

## Interface
Parameters:
- IN_W, default 11: width of each signed two's-complement gradient input. Sobel range ±1020 fits; −2^(IN_W−1) is legal.
- OUT_W, default 16: radicand output width; matches the square-root input.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  gradient pair valid.
- in_ready  out  1  block idle and able to accept a pair.
- gx  in  IN_W  signed horizontal gradient.
- gy  in  IN_W  signed vertical gradient.
- out_valid  out  1  radicand valid.
- out_ready  in  1  downstream accepts the radicand.
- radicand  out  OUT_W  saturated Gx² + Gy².
- sat  out  1  high with out_valid when the true sum was ≥ 2^OUT_W.

## Operation
- FSM states: IDLE, SQX, SQY, DONE. Bit counter: ceil(log2(IN_W)) bits. Accumulator: 2·IN_W+1 bits.
- IDLE:
  - in_ready = 1. On in_valid && in_ready, capture |gx| and |gy| as IN_W-bit unsigned magnitudes (|−2^(IN_W−1)| = 2^(IN_W−1), no overflow).
  - Clear the accumulator, set cnt = 0, go to SQX.
- SQX, one edge per bit:
  - If mag_x[cnt] = 1, do acc += mag_x << cnt.
  - cnt increments. At cnt = IN_W−1 the edge processes the last bit, resets cnt to 0, and moves to SQY.
- SQY: identical to SQX using mag_y. After bit IN_W−1 it moves to DONE.
  - The radicand and sat registers load on that same edge: if acc ≥ 2^OUT_W, radicand = all ones and sat = 1; else radicand = acc[OUT_W−1:0] and sat = 0.
- DONE:
  - out_valid = 1. radicand and sat are held stable.
  - On out_valid && out_ready, go to IDLE and drop out_valid.
- in_valid, gx and gy are ignored outside IDLE. Captured magnitudes are unaffected by input changes mid-computation.
- Outputs while not in DONE: radicand and sat keep their last loaded values. They are meaningful only when out_valid = 1.
- in_ready = (state == IDLE) && !rst. out_valid = (state == DONE).

## Timing
- Reset values: state IDLE, out_valid 0, radicand 0, sat 0, acc 0, cnt 0. in_ready is 0 during the reset cycle and 1 on the first cycle after.
- Reset mid-operation (SQX, SQY or DONE) aborts the transaction. Partial results are discarded, the block is back in IDLE the next cycle, and no out_valid is emitted for the aborted pair.
- Latency: the accept edge is A. out_valid is high in the cycle after edge A + 2·IN_W (A + 22 at default).
- Throughput with out_ready tied high:
  - DONE lasts one cycle, then one IDLE cycle follows.
  - Next accept edge ≥ A + 2·IN_W + 2 (24 at default).
- No pipelining or bypass: exactly one transaction is in flight.
- in_ready and out_valid are never high together.

## Test plan
- Basic value: rst for 2 cycles, then gx = 3, gy = 4, in_valid for one cycle, out_ready = 1.
  - Expect radicand = 25 and sat = 0.
  - out_valid rises exactly 22 edges after accept and is high for 1 cycle.
  - in_ready low from accept until after the handoff.
- Negative input and zero: gx = −255, gy = 0 → radicand = 65025, sat = 0.
- Saturation boundaries:
  - gx = 181, gy = 181 → 65522, sat = 0.
  - gx = 256, gy = 0 → 0xFFFF, sat = 1.
  - gx = −1024, gy = 1023 (true 2095105) → 0xFFFF, sat = 1.
- Backpressure and ignored inputs: out_ready = 0 for 5 cycles while in DONE.
  - radicand and sat stay stable and in_ready stays 0.
  - in_valid held high with changing gx/gy during the busy period does not alter the result.
  - Releasing out_ready completes the handoff; the next pair is accepted the cycle after.
- Reset mid-operation: assert rst at cycle 15 of a gx = 100, gy = 100 transaction (during SQY).
  - Expect out_valid never rises for that pair and in_ready = 1 the cycle after reset deasserts.
  - A following gx = 1, gy = −1 yields radicand = 2.
